deconv_result_streamer: RTL

Downstream drain stage for `deconv2D`. After the transposed-convolution core asserts `done`, this block walks the core's result RAM through `result_address`/`final_output` in raster order over the valid output region only. It scales each 4×`pixel_bits` accumulator by a right shift and saturates it to `pixel_bits`. Results leave on a valid/ready stream with an end-of-frame marker.

---
 rtl/deconv_result_streamer.sv | 116 +++++++++++
 1 files changed

// File: rtl/deconv_result_streamer.sv
// deconv_result_streamer: drains the deconv2D result RAM in raster order over the valid output
// region, scaling and saturating each accumulator onto a valid/ready stream with end-of-frame.
module deconv_result_streamer #(
    parameter int N          = 2,
    parameter int K          = 3,
    parameter int pixel_bits = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           conv_done,
    input  logic [$clog2(K)-1:0]           stride,
    input  logic [$clog2(K)-1:0]           kernel_width,
    input  logic [4:0]                     shift,
    output logic [$clog2(N*K*N*K)-1:0]     result_address,
    input  logic [pixel_bits*4-1:0]        final_output,
    output logic [pixel_bits-1:0]          out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           cfg_err
);
    localparam int AW = $clog2(N*K*N*K);
    localparam int WW = $clog2(N*K) + 2;
    localparam int DW = pixel_bits * 4;
    localparam logic [WW-1:0] NK = WW'(N*K);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT_CLR} state_t;

    state_t                state, state_n;
    logic [WW-1:0]         raw_w, out_w, r, c;
    logic [AW-1:0]         row_base;
    logic [4:0]            shift_q;
    logic [pixel_bits:0]   fifo_mem [2];
    logic [pixel_bits:0]   head;
    logic [1:0]            count, count_n;
    logic [DW-1:0]         y;
    logic [pixel_bits-1:0] sat;
    logic                  wr_ptr, rd_ptr, start, issue, pop, col_end, last_issue;
    logic                  zero_pend, frame_done_n;

    assign raw_w      = WW'(N - 1) * WW'(stride) + WW'(kernel_width);
    assign start      = state == IDLE && conv_done;
    // Read data follows result_address combinationally, so an issued read lands in the FIFO that same cycle.
    assign issue      = state == STREAM && count < 2'd2;
    assign pop        = out_valid && out_ready;
    assign col_end    = c == out_w - 1'b1;
    assign last_issue = issue && col_end && r == out_w - 1'b1;
    assign count_n    = count + 2'(issue) - 2'(pop);
    assign y          = final_output >> shift_q;
    assign sat        = |y[DW-1:pixel_bits] ? '1 : y[pixel_bits-1:0];
    assign head       = fifo_mem[rd_ptr];
    assign out_valid  = count != 2'd0;
    assign out_data   = head[pixel_bits-1:0];
    assign out_last   = out_valid && head[pixel_bits];
    assign busy       = state != IDLE;
    assign frame_done_n = (state == DRAIN && count_n == 2'd0) || zero_pend;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = conv_done ? (raw_w == '0 ? WAIT_CLR : STREAM) : IDLE;
            STREAM:   state_n = last_issue ? DRAIN : STREAM;
            DRAIN:    state_n = count_n == 2'd0 ? WAIT_CLR : DRAIN;
            WAIT_CLR: state_n = conv_done ? WAIT_CLR : IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_address <= '0;
            row_base       <= '0;
            r              <= '0;
            c              <= '0;
            out_w          <= '0;
            shift_q        <= '0;
            cfg_err        <= 1'b0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            count          <= '0;
            fifo_mem[0]    <= '0;
            fifo_mem[1]    <= '0;
            frame_done     <= 1'b0;
            zero_pend      <= 1'b0;
        end else begin
            frame_done <= frame_done_n;
            zero_pend  <= start && raw_w == '0;
            count      <= count_n;
            if (start) begin
                out_w          <= raw_w > NK ? NK : raw_w;
                cfg_err        <= raw_w > NK;
                shift_q        <= shift;
                r              <= '0;
                c              <= '0;
                row_base       <= '0;
                result_address <= '0;
            end else if (issue) begin
                c              <= col_end ? '0 : c + 1'b1;
                r              <= col_end ? r + 1'b1 : r;
                row_base       <= col_end ? row_base + AW'(N*K) : row_base;
                result_address <= col_end ? row_base + AW'(N*K) : result_address + 1'b1;
            end
            if (issue) begin
                fifo_mem[wr_ptr] <= {last_issue, sat};
                wr_ptr           <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
        end
    end
endmodule
